// File: rtl/sparc_decode_pkg.sv
// Shared encodings for the SPARC decode stage: opcode fields, ALU and
// memory-size codes, and the decoded control record.
package sparc_decode_pkg;

  localparam logic [1:0] OP_FMT2 = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;

  localparam logic [2:0] OP2_SETHI = 3'b100;

  localparam logic [5:0] OP3_ADD  = 6'b000000;
  localparam logic [5:0] OP3_AND  = 6'b000001;
  localparam logic [5:0] OP3_OR   = 6'b000010;
  localparam logic [5:0] OP3_SUB  = 6'b000100;
  localparam logic [5:0] OP3_UMUL = 6'b001010;
  localparam logic [5:0] OP3_SMUL = 6'b001011;
  localparam logic [5:0] OP3_UDIV = 6'b001110;
  localparam logic [5:0] OP3_SLL  = 6'b100101;
  localparam logic [5:0] OP3_SRL  = 6'b100110;
  localparam logic [5:0] OP3_SRA  = 6'b100111;

  localparam logic [5:0] OP3_LD   = 6'b000000;
  localparam logic [5:0] OP3_LDUB = 6'b000001;
  localparam logic [5:0] OP3_LDUH = 6'b000010;
  localparam logic [5:0] OP3_LDD  = 6'b000011;
  localparam logic [5:0] OP3_ST   = 6'b000100;
  localparam logic [5:0] OP3_STB  = 6'b000101;
  localparam logic [5:0] OP3_STH  = 6'b000110;
  localparam logic [5:0] OP3_STD  = 6'b000111;
  localparam logic [5:0] OP3_LDSB = 6'b001001;
  localparam logic [5:0] OP3_LDSH = 6'b001010;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_DIV   = 3'b101;
  localparam logic [2:0] ALU_SHIFT = 3'b110;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic [1:0] mem_size;
    logic       mem_signed;
    logic [2:0] alu_op;
    logic       signed_mul;
    logic       left_shift;
    logic       arith_shift;
    logic       illegal;
    logic       is_alu;
    logic       is_mem;
    logic       is_store;
    logic       is_dw;
    logic       is_sethi;
    logic       is_shift;
    logic       use_imm;
  } ctrl_t;

  // Double-word beats target the even register first, then the odd one.
  function automatic logic [4:0] dw_rd(input logic [4:0] rd, input logic second);
    return second ? (rd | 5'd1) : (rd & 5'b11110);
  endfunction

endpackage

// File: rtl/sparc_decode_comb.sv
// Purely combinational opcode decode: op/op3/i -> control record.
module sparc_decode_comb
  import sparc_decode_pkg::*;
#(
  parameter bit ENABLE_DW = 1'b1
) (
  input  logic [1:0] op,
  input  logic [5:0] op3,
  input  logic       i_bit,
  output ctrl_t      ctrl
);

  // Classify the instruction; undefined op3 values collapse to illegal
  // with every enable cleared.
  always_comb begin
    ctrl = '0;
    case (op)
      OP_ALU: begin
        ctrl.is_alu    = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = i_bit;
        case (op3)
          OP3_ADD:  ctrl.alu_op = ALU_ADD;
          OP3_AND:  ctrl.alu_op = ALU_AND;
          OP3_OR:   ctrl.alu_op = ALU_OR;
          OP3_SUB:  ctrl.alu_op = ALU_SUB;
          OP3_UMUL: ctrl.alu_op = ALU_MUL;
          OP3_SMUL: begin
            ctrl.alu_op     = ALU_MUL;
            ctrl.signed_mul = 1'b1;
          end
          OP3_UDIV: ctrl.alu_op = ALU_DIV;
          OP3_SLL: begin
            ctrl.alu_op     = ALU_SHIFT;
            ctrl.is_shift   = 1'b1;
            ctrl.left_shift = 1'b1;
          end
          OP3_SRL: begin
            ctrl.alu_op   = ALU_SHIFT;
            ctrl.is_shift = 1'b1;
          end
          OP3_SRA: begin
            ctrl.alu_op      = ALU_SHIFT;
            ctrl.is_shift    = 1'b1;
            ctrl.arith_shift = 1'b1;
          end
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_MEM: begin
        ctrl.is_mem   = 1'b1;
        ctrl.use_imm  = i_bit;
        ctrl.mem_size = SIZE_WORD;
        case (op3)
          OP3_LD: begin
            ctrl.mem_read  = 1'b1;
            ctrl.reg_write = 1'b1;
          end
          OP3_LDUB, OP3_LDSB: begin
            ctrl.mem_read   = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_size   = SIZE_BYTE;
            ctrl.mem_signed = (op3 == OP3_LDSB);
          end
          OP3_LDUH, OP3_LDSH: begin
            ctrl.mem_read   = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_size   = SIZE_HALF;
            ctrl.mem_signed = (op3 == OP3_LDSH);
          end
          OP3_LDD: begin
            if (ENABLE_DW) begin
              ctrl.mem_read  = 1'b1;
              ctrl.reg_write = 1'b1;
              ctrl.is_dw     = 1'b1;
            end else begin
              ctrl         = '0;
              ctrl.illegal = 1'b1;
            end
          end
          OP3_ST: begin
            ctrl.mem_write = 1'b1;
            ctrl.is_store  = 1'b1;
          end
          OP3_STB: begin
            ctrl.mem_write = 1'b1;
            ctrl.is_store  = 1'b1;
            ctrl.mem_size  = SIZE_BYTE;
          end
          OP3_STH: begin
            ctrl.mem_write = 1'b1;
            ctrl.is_store  = 1'b1;
            ctrl.mem_size  = SIZE_HALF;
          end
          OP3_STD: begin
            if (ENABLE_DW) begin
              ctrl.mem_write = 1'b1;
              ctrl.is_store  = 1'b1;
              ctrl.is_dw     = 1'b1;
            end else begin
              ctrl         = '0;
              ctrl.illegal = 1'b1;
            end
          end
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_FMT2: begin
        if (op3[5:3] == OP2_SETHI) begin
          ctrl.is_sethi  = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_OR;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sparc_decode_stage.sv
// SPARC integer decode stage: valid/ready input, register-file reads,
// registered control/operand bundle, two-beat ldd/std sequencing.
module sparc_decode_stage
  import sparc_decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit ENABLE_DW = 1'b1,
  parameter bit ZERO_R0   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic [4:0]      rf_raddr_a,
  output logic [4:0]      rf_raddr_b,
  output logic [4:0]      rf_raddr_c,
  input  logic [XLEN-1:0] rf_rdata_a,
  input  logic [XLEN-1:0] rf_rdata_b,
  input  logic [XLEN-1:0] rf_rdata_c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            mem_write,
  output logic            mem_read,
  output logic            reg_write,
  output logic [1:0]      mem_access_size,
  output logic            mem_access_signed,
  output logic [2:0]      alu_op,
  output logic            signed_mul,
  output logic            left_shift,
  output logic            arith_shift,
  output logic [XLEN-1:0] src_a,
  output logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] src_c,
  output logic [4:0]      rd,
  output logic            dw_second,
  output logic            illegal
);

  typedef enum logic {IDLE = 1'b0, DW2 = 1'b1} state_t;

  state_t        state, state_next;
  logic [31:0]   dw_instr;
  logic [31:0]   cur_instr;
  logic          beat2;
  ctrl_t         ctrl;
  logic [4:0]    f_rd, f_rs1, f_rs2, rd_eff;
  logic [XLEN-1:0] opa, opb, opc, simm_ext, shamt, sethi_val, op2v;
  logic [XLEN-1:0] nxt_a, nxt_b, nxt_c;
  logic          slot_free, accept, load;

  function automatic logic [XLEN-1:0] rd_val(input logic [4:0] a, input logic [XLEN-1:0] d);
    return (ZERO_R0 && a == 5'd0) ? '0 : d;
  endfunction

  // During DW2 the latched ldd/std drives decode and the RF read ports.
  assign beat2     = (state == DW2);
  assign cur_instr = beat2 ? dw_instr : instruction;

  sparc_decode_comb #(.ENABLE_DW(ENABLE_DW)) u_comb (
    .op    (cur_instr[31:30]),
    .op3   (cur_instr[24:19]),
    .i_bit (cur_instr[13]),
    .ctrl  (ctrl)
  );

  assign f_rd   = cur_instr[29:25];
  assign f_rs1  = cur_instr[18:14];
  assign f_rs2  = cur_instr[4:0];
  assign rd_eff = ctrl.is_dw ? dw_rd(f_rd, beat2) : f_rd;

  // Port a carries store data (rd) for stores, rs1 otherwise.
  assign rf_raddr_a = ctrl.is_store ? rd_eff : f_rs1;
  assign rf_raddr_b = f_rs1;
  assign rf_raddr_c = f_rs2;

  assign opa = rd_val(rf_raddr_a, rf_rdata_a);
  assign opb = rd_val(rf_raddr_b, rf_rdata_b);
  assign opc = rd_val(rf_raddr_c, rf_rdata_c);

  assign simm_ext  = XLEN'($signed(cur_instr[12:0]));
  assign shamt     = XLEN'(cur_instr[4:0]);
  assign sethi_val = XLEN'({cur_instr[21:0], 10'b0});
  assign op2v      = ctrl.use_imm ? (ctrl.is_shift ? shamt : simm_ext) : opc;

  // Operand steering per instruction class; the second ldd/std beat
  // addresses the following word.
  always_comb begin
    nxt_a = '0;
    nxt_b = '0;
    nxt_c = '0;
    if (ctrl.is_alu) begin
      nxt_a = opa;
      nxt_b = op2v;
    end else if (ctrl.is_mem) begin
      nxt_a = opa;
      nxt_b = opb;
      nxt_c = op2v + (beat2 ? XLEN'(32'd4) : '0);
    end else if (ctrl.is_sethi) begin
      nxt_b = sethi_val;
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign load      = !flush && (accept || (beat2 && slot_free));

  // Double-word sequencer next state; flush aborts any pending beat.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (accept && ctrl.is_dw) state_next = DW2;
        DW2:  if (slot_free)            state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Hold the ldd/std word so beat 2 can be decoded after in_ready drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                dw_instr <= '0;
    else if (!flush && accept && ctrl.is_dw)   dw_instr <= instruction;
  end

  // Output bundle register: load on issue, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      mem_write         <= 1'b0;
      mem_read          <= 1'b0;
      reg_write         <= 1'b0;
      mem_access_size   <= 2'b00;
      mem_access_signed <= 1'b0;
      alu_op            <= 3'b000;
      signed_mul        <= 1'b0;
      left_shift        <= 1'b0;
      arith_shift       <= 1'b0;
      src_a             <= '0;
      src_b             <= '0;
      src_c             <= '0;
      rd                <= 5'd0;
      dw_second         <= 1'b0;
      illegal           <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid         <= 1'b1;
      mem_write         <= ctrl.mem_write;
      mem_read          <= ctrl.mem_read;
      reg_write         <= ctrl.reg_write;
      mem_access_size   <= ctrl.mem_size;
      mem_access_signed <= ctrl.mem_signed;
      alu_op            <= ctrl.alu_op;
      signed_mul        <= ctrl.signed_mul;
      left_shift        <= ctrl.left_shift;
      arith_shift       <= ctrl.arith_shift;
      src_a             <= nxt_a;
      src_b             <= nxt_b;
      src_c             <= nxt_c;
      rd                <= rd_eff;
      dw_second         <= beat2;
      illegal           <= ctrl.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sparc_decode_stage.sv
// Scoreboard bench: tasks push hand-derived expected bundles, a negedge
// monitor pops and compares every bundle the execute side accepts.
module tb_sparc_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic [4:0]  rf_raddr_a, rf_raddr_b, rf_raddr_c;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_rdata_c;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        mem_write, mem_read, reg_write, mem_access_signed;
  logic [1:0]  mem_access_size;
  logic [2:0]  alu_op;
  logic        signed_mul, left_shift, arith_shift, dw_second, illegal;
  logic [31:0] src_a, src_b, src_c;
  logic [4:0]  rd;

  always #5 clk = ~clk;

  sparc_decode_stage #(.XLEN(32), .ENABLE_DW(1'b1), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_raddr_c(rf_raddr_c),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_rdata_c(rf_rdata_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_write(mem_write), .mem_read(mem_read), .reg_write(reg_write),
    .mem_access_size(mem_access_size), .mem_access_signed(mem_access_signed),
    .alu_op(alu_op), .signed_mul(signed_mul), .left_shift(left_shift),
    .arith_shift(arith_shift), .src_a(src_a), .src_b(src_b), .src_c(src_c),
    .rd(rd), .dw_second(dw_second), .illegal(illegal)
  );

  // Register file contents; r0 holds junk to expose missing zeroing.
  logic [31:0] regs [32];
  always_comb begin
    rf_rdata_a = regs[rf_raddr_a];
    rf_rdata_b = regs[rf_raddr_b];
    rf_rdata_c = regs[rf_raddr_c];
  end

  typedef struct packed {
    logic        mem_write, mem_read, reg_write;
    logic [1:0]  size;
    logic        msigned;
    logic [2:0]  alu_op;
    logic        signed_mul, left_shift, arith_shift;
    logic [31:0] src_a, src_b, src_c;
    logic [4:0]  rd;
    logic        dw_second, illegal;
  } bundle_t;

  bundle_t act;
  assign act = {mem_write, mem_read, reg_write, mem_access_size, mem_access_signed,
                alu_op, signed_mul, left_shift, arith_shift, src_a, src_b, src_c,
                rd, dw_second, illegal};

  bundle_t exp_q[$];
  bundle_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] f3(input logic [1:0] op, input logic [4:0] rdf,
                                     input logic [5:0] op3, input logic [4:0] rs1,
                                     input logic i, input logic [12:0] low);
    return {op, rdf, op3, rs1, i, low};
  endfunction

  function automatic bundle_t alu_b(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] r);
    bundle_t e = '0;
    e.reg_write = 1'b1; e.alu_op = op; e.src_a = a; e.src_b = b; e.rd = r;
    return e;
  endfunction

  function automatic bundle_t ld_b(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] c, input logic [4:0] r);
    bundle_t e = '0;
    e.mem_read = 1'b1; e.reg_write = 1'b1; e.size = sz; e.msigned = sg;
    e.src_a = a; e.src_b = b; e.src_c = c; e.rd = r;
    return e;
  endfunction

  function automatic bundle_t st_b(input logic [1:0] sz, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] c, input logic [4:0] r);
    bundle_t e = '0;
    e.mem_write = 1'b1; e.size = sz; e.src_a = a; e.src_b = b; e.src_c = c; e.rd = r;
    return e;
  endfunction

  // Scoreboard consumer: a bundle transfers when valid && ready at the edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL bundle: unexpected bundle got=%h", act);
      end else begin
        mon_e = exp_q.pop_front();
        if (act !== mon_e) begin
          n_bad++;
          $display("FAIL bundle: got=%h expected=%h", act, mon_e);
        end
      end
    end
  end

  // Present one instruction until accepted (bounded).
  task automatic issue(input logic [31:0] ins);
    int n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    instruction = ins;
    do begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: in_ready=%b required 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got=%b expected=0", out_valid); end
    n_cmp++;
    if (act !== '0) begin n_bad++; $display("FAIL reset_bundle: got=%h expected=0", act); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got=%b expected=1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    bundle_t e;
    out_ready = 1'b1;
    exp_q.push_back(alu_b(3'b010, 32'd5, 32'd7, 5'd3));
    issue(f3(2'b10, 5'd3, 6'b000000, 5'd1, 1'b0, 13'd2));       // add r3,r1,r2
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_latency: out_valid=%b expected=1", out_valid); end
    @(posedge clk); #1;
    // back-to-back ALU forms
    exp_q.push_back(alu_b(3'b011, 32'd5, 32'hFFFF_FFFF, 5'd5));
    e = alu_b(3'b110, 32'd5, 32'd3, 5'd4); e.arith_shift = 1'b1; exp_q.push_back(e);
    exp_q.push_back(alu_b(3'b110, 32'd7, 32'd3, 5'd12));
    e = alu_b(3'b110, 32'd5, 32'd7, 5'd8); e.left_shift = 1'b1; exp_q.push_back(e);
    e = alu_b(3'b100, 32'd5, 32'd7, 5'd9); e.signed_mul = 1'b1; exp_q.push_back(e);
    exp_q.push_back(alu_b(3'b100, 32'd5, 32'd7, 5'd10));
    exp_q.push_back(alu_b(3'b101, 32'd7, 32'd5, 5'd11));
    exp_q.push_back(alu_b(3'b001, 32'd0, 32'd7, 5'd13));
    exp_q.push_back(alu_b(3'b000, 32'hA, 32'hF, 5'd14));
    exp_q.push_back(alu_b(3'b001, 32'd0, 32'h048D_1400, 5'd15));
    issue(f3(2'b10, 5'd5,  6'b000100, 5'd1, 1'b1, 13'h1FFF));   // sub r5,r1,-1
    issue(f3(2'b10, 5'd4,  6'b100111, 5'd1, 1'b1, 13'd3));      // sra r4,r1,3
    issue(f3(2'b10, 5'd12, 6'b100110, 5'd2, 1'b1, 13'h1FE3));   // srl r12,r2,3 (high bits ignored)
    issue(f3(2'b10, 5'd8,  6'b100101, 5'd1, 1'b0, 13'd2));      // sll r8,r1,r2
    issue(f3(2'b10, 5'd9,  6'b001011, 5'd1, 1'b0, 13'd2));      // smul
    issue(f3(2'b10, 5'd10, 6'b001010, 5'd1, 1'b0, 13'd2));      // umul
    issue(f3(2'b10, 5'd11, 6'b001110, 5'd2, 1'b0, 13'd1));      // udiv r11,r2,r1
    issue(f3(2'b10, 5'd13, 6'b000010, 5'd0, 1'b0, 13'd2));      // or r13,r0,r2
    issue(f3(2'b10, 5'd14, 6'b000001, 5'd6, 1'b1, 13'h00F));    // and r14,r6,0xF
    issue({2'b00, 5'd15, 3'b100, 22'h12345});                   // sethi
    drain(2);
  endtask

  task automatic test_mem_single;
    out_ready = 1'b1;
    exp_q.push_back(ld_b(2'b10, 1'b0, 32'd5, 32'd5, 32'd7, 5'd16));
    exp_q.push_back(ld_b(2'b01, 1'b0, 32'd7, 32'd7, 32'hFFFF_FFFE, 5'd17));
    exp_q.push_back(ld_b(2'b01, 1'b1, 32'd5, 32'd5, 32'd7, 5'd20));
    exp_q.push_back(ld_b(2'b00, 1'b0, 32'd0, 32'd0, 32'd5, 5'd21));
    exp_q.push_back(st_b(2'b00, 32'hA, 32'd5, 32'd4, 5'd6));
    exp_q.push_back(st_b(2'b01, 32'hB, 32'd7, 32'd5, 5'd7));
    exp_q.push_back(st_b(2'b10, 32'd0, 32'd5, 32'd0, 5'd0));
    issue(f3(2'b11, 5'd16, 6'b000000, 5'd1, 1'b0, 13'd2));      // ld r16,[r1+r2]
    issue(f3(2'b11, 5'd17, 6'b000010, 5'd2, 1'b1, 13'h1FFE));   // lduh r17,[r2-2]
    issue(f3(2'b11, 5'd20, 6'b001010, 5'd1, 1'b0, 13'd2));      // ldsh r20,[r1+r2]
    issue(f3(2'b11, 5'd21, 6'b000001, 5'd0, 1'b0, 13'd1));      // ldub r21,[r0+r1]
    issue(f3(2'b11, 5'd6,  6'b000101, 5'd1, 1'b1, 13'd4));      // stb r6,[r1+4]
    issue(f3(2'b11, 5'd7,  6'b000110, 5'd2, 1'b0, 13'd1));      // sth r7,[r2+r1]
    issue(f3(2'b11, 5'd0,  6'b000100, 5'd1, 1'b1, 13'd0));      // st r0,[r1]
    drain(2);
  endtask

  task automatic test_backpressure;
    bundle_t e_ldsb, e_ld;
    e_ldsb = ld_b(2'b00, 1'b1, 32'd5, 32'd5, 32'd5, 5'd18);
    e_ld   = ld_b(2'b10, 1'b0, 32'd7, 32'd7, 32'd0, 5'd19);
    out_ready = 1'b0;
    exp_q.push_back(e_ldsb);
    issue(f3(2'b11, 5'd18, 6'b001001, 5'd1, 1'b1, 13'd5));      // ldsb r18,[r1+5]
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      instruction = f3(2'b11, 5'd19, 6'b000000, 5'd2, 1'b1, 13'd0);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_handshake: out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
      end
      n_cmp++;
      if (act !== e_ldsb) begin n_bad++; $display("FAIL stall_hold: got=%h expected=%h", act, e_ldsb); end
      @(posedge clk); #1;
    end
    exp_q.push_back(e_ld);
    out_ready = 1'b1;
    issue(f3(2'b11, 5'd19, 6'b000000, 5'd2, 1'b1, 13'd0));      // ld r19,[r2]
    drain(2);
  endtask

  task automatic test_double_word;
    bundle_t e;
    out_ready = 1'b1;
    exp_q.push_back(st_b(2'b10, 32'hA, 32'd5, 32'd8, 5'd6));
    e = st_b(2'b10, 32'hB, 32'd5, 32'd12, 5'd7); e.dw_second = 1'b1; exp_q.push_back(e);
    issue(f3(2'b11, 5'd6, 6'b000111, 5'd1, 1'b1, 13'd8));       // std r6,[r1+8]
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL dw2_in_ready: got=%b expected=0", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dw_done_in_ready: got=%b expected=1", in_ready); end
    @(posedge clk); #1;
    exp_q.push_back(ld_b(2'b10, 1'b0, 32'd5, 32'd5, 32'd7, 5'd8));
    e = ld_b(2'b10, 1'b0, 32'd5, 32'd5, 32'd11, 5'd9); e.dw_second = 1'b1; exp_q.push_back(e);
    exp_q.push_back(alu_b(3'b010, 32'd5, 32'd7, 5'd3));
    issue(f3(2'b11, 5'd9, 6'b000011, 5'd1, 1'b0, 13'd2));       // ldd r9,[r1+r2] -> r8/r9
    issue(f3(2'b10, 5'd3, 6'b000000, 5'd1, 1'b0, 13'd2));       // add right behind it
    drain(2);
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    issue(f3(2'b11, 5'd9, 6'b000011, 5'd1, 1'b0, 13'd2));       // ldd, beat 1 held
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_pre: out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_dw2: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    // instruction presented together with flush is dropped
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    instruction = f3(2'b10, 5'd3, 6'b000000, 5'd1, 1'b0, 13'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_quiet: out_valid=%b expected=0 cycle %0d", out_valid, k); end
    end
    @(posedge clk); #1;
    exp_q.push_back(alu_b(3'b010, 32'd5, 32'd7, 5'd3));
    issue(f3(2'b10, 5'd3, 6'b000000, 5'd1, 1'b0, 13'd2));
    drain(2);
  endtask

  task automatic test_illegal;
    bundle_t e;
    out_ready = 1'b1;
    e = '0; e.illegal = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(e);
    exp_q.push_back(bundle_t'('0));
    exp_q.push_back(bundle_t'('0));
    issue(f3(2'b10, 5'd0, 6'b111111, 5'd0, 1'b0, 13'd0));       // undefined ALU op3
    issue(f3(2'b11, 5'd0, 6'b001111, 5'd0, 1'b0, 13'd0));       // undefined memory op3
    issue({2'b00, 5'd0, 3'b010, 22'd0});                        // branch: no enables
    issue({2'b01, 30'd0});                                      // call: no enables
    drain(2);
  endtask

  task automatic test_reset_mid_dw;
    out_ready = 1'b0;
    issue(f3(2'b11, 5'd6, 6'b000111, 5'd1, 1'b1, 13'd8));       // std, beat 1 held in DW2
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid: got=%b expected=0", out_valid); end
    n_cmp++;
    if (act !== '0) begin n_bad++; $display("FAIL async_reset_bundle: got=%h expected=0", act); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_abort_dw: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    exp_q.push_back(alu_b(3'b011, 32'd5, 32'hFFFF_FFFF, 5'd5));
    issue(f3(2'b10, 5'd5, 6'b000100, 5'd1, 1'b1, 13'h1FFF));
    drain(2);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) regs[k] = 32'h100 + k;
    regs[0] = 32'hDEAD_BEEF;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    regs[6] = 32'hA;
    regs[7] = 32'hB;
    test_reset();
    test_alu();
    test_mem_single();
    test_backpressure();
    test_double_word();
    test_flush();
    test_illegal();
    test_reset_mid_dw();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d bundles outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
